// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, variable-latency imem handshake and IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to deliver the word fetched alongside a taken branch as a delay slot.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_stall,
    input  logic        IF_ID_pipeline_stall,
    input  logic        PCSrc_ID,
    input  logic [31:0] Branch_Target_ID,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PC_Plus4_ID,
    output logic        Valid_ID,
    output logic [15:0] Stall_Count
);

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        WAIT    = 2'b01,
        DISCARD = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pc_plus4_s;
    logic        redirect_pending_r;
    logic        redirect_pending_s;
    logic [31:0] redirect_target_r;
    logic [31:0] redirect_target_s;
    logic        load_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign imem_addr  = pc_r;

    // Next-state, next-PC and redirect bookkeeping; any cycle without a load is a bubble.
    always_comb begin
        state_s            = state_r;
        pc_s               = pc_r;
        redirect_pending_s = redirect_pending_r;
        redirect_target_s  = redirect_target_r;
        load_s             = 1'b0;
        if (pc_stall) begin
            load_s = 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (imem_valid) begin
                        if (PCSrc_ID) begin
                            pc_s = Branch_Target_ID;
`ifdef BRANCH_DELAY_SLOT_EN
                            load_s = 1'b1;
`else
                            load_s = 1'b0;
`endif
                        end else begin
                            pc_s   = pc_plus4_s;
                            load_s = 1'b1;
                        end
                    end else if (PCSrc_ID) begin
                        redirect_pending_s = 1'b1;
                        redirect_target_s  = Branch_Target_ID;
`ifdef BRANCH_DELAY_SLOT_EN
                        state_s = WAIT;
`else
                        state_s = DISCARD;
`endif
                    end else begin
                        state_s = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        state_s            = FETCH;
                        redirect_pending_s = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
                        load_s = 1'b1;
`else
                        load_s = ~PCSrc_ID;
`endif
                        // A branch resolved in the arrival cycle supersedes any older redirect.
                        if (PCSrc_ID) begin
                            pc_s = Branch_Target_ID;
                        end else if (redirect_pending_r) begin
                            pc_s = redirect_target_r;
                        end else begin
                            pc_s = pc_plus4_s;
                        end
                    end else if (PCSrc_ID) begin
                        redirect_pending_s = 1'b1;
                        redirect_target_s  = Branch_Target_ID;
`ifdef BRANCH_DELAY_SLOT_EN
                        state_s = WAIT;
`else
                        state_s = DISCARD;
`endif
                    end else begin
                        state_s = WAIT;
                    end
                end
                DISCARD: begin
                    if (imem_valid) begin
                        state_s            = FETCH;
                        redirect_pending_s = 1'b0;
                        pc_s               = PCSrc_ID ? Branch_Target_ID : redirect_target_r;
                    end else if (PCSrc_ID) begin
                        redirect_target_s = Branch_Target_ID;
                    end else begin
                        state_s = DISCARD;
                    end
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end
    end

    // FSM state, PC and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r            <= FETCH;
            pc_r               <= RESET_PC;
            redirect_pending_r <= 1'b0;
            redirect_target_r  <= 32'h0000_0000;
        end else begin
            state_r            <= state_s;
            pc_r               <= pc_s;
            redirect_pending_r <= redirect_pending_s;
            redirect_target_r  <= redirect_target_s;
        end
    end

    // IF/ID register; the pipeline stall freezes it over both loads and bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            Instruction_ID <= 32'h0000_0000;
            PC_Plus4_ID    <= 32'h0000_0000;
            Valid_ID       <= 1'b0;
        end else if (IF_ID_pipeline_stall) begin
            Instruction_ID <= Instruction_ID;
            PC_Plus4_ID    <= PC_Plus4_ID;
            Valid_ID       <= Valid_ID;
        end else if (load_s) begin
            Instruction_ID <= imem_rdata;
            PC_Plus4_ID    <= pc_plus4_s;
            Valid_ID       <= 1'b1;
        end else begin
            Instruction_ID <= 32'h0000_0000;
            PC_Plus4_ID    <= PC_Plus4_ID;
            Valid_ID       <= 1'b0;
        end
    end

    // Lost-fetch counter: every cycle that delivers no word, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            Stall_Count <= 16'h0000;
        end else if (!load_s && (Stall_Count != 16'hFFFF)) begin
            Stall_Count <= Stall_Count + 16'd1;
        end else begin
            Stall_Count <= Stall_Count;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table for the documented scenarios,
// then randomized traffic against a transaction-level reference model.
module tb_if_fetch_stage;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        pc_stall;
    logic        IF_ID_pipeline_stall;
    logic        PCSrc_ID;
    logic [31:0] Branch_Target_ID;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] Instruction_ID;
    logic [31:0] PC_Plus4_ID;
    logic        Valid_ID;
    logic [15:0] Stall_Count;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                 (clk),
        .reset               (reset),
        .pc_stall            (pc_stall),
        .IF_ID_pipeline_stall(IF_ID_pipeline_stall),
        .PCSrc_ID            (PCSrc_ID),
        .Branch_Target_ID    (Branch_Target_ID),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .imem_valid          (imem_valid),
        .Instruction_ID      (Instruction_ID),
        .PC_Plus4_ID         (PC_Plus4_ID),
        .Valid_ID            (Valid_ID),
        .Stall_Count         (Stall_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ps;
        logic        fs;
        logic        br;
        logic [31:0] tgt;
        logic        vld;
        logic [31:0] rd;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [15:0] e_cnt;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: fetch address, pending redirect and whether the outstanding word is dropped.
    logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
    logic        m_pend, m_drop, m_valid;
    logic [15:0] m_cnt;

    function automatic logic [31:0] w(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic add(input logic rst, input logic ps, input logic fs, input logic br,
                       input logic [31:0] tgt, input logic vld, input logic [31:0] rd,
                       input logic [31:0] e_addr, input logic [31:0] e_instr,
                       input logic e_valid, input int e_cnt, input logic [31:0] e_pc4);
        vec_t v;
        v.rst = rst; v.ps = ps; v.fs = fs; v.br = br; v.tgt = tgt; v.vld = vld; v.rd = rd;
        v.e_addr = e_addr; v.e_instr = e_instr; v.e_valid = e_valid;
        v.e_cnt = e_cnt[15:0]; v.e_pc4 = e_pc4;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic deliver;
        logic [31:0] old_pc;
        if (reset) begin
            m_pc = 32'h0000_0000; m_tgt = 32'h0; m_pend = 1'b0; m_drop = 1'b0;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
        end else begin
            deliver = 1'b0;
            old_pc  = m_pc;
            if (!pc_stall) begin
                if (imem_valid) begin
                    deliver = !m_drop && (!PCSrc_ID || DS);
                    if (PCSrc_ID)    m_pc = Branch_Target_ID;
                    else if (m_pend) m_pc = m_tgt;
                    else             m_pc = m_pc + 32'd4;
                    m_pend = 1'b0;
                    m_drop = 1'b0;
                end else if (PCSrc_ID) begin
                    m_pend = 1'b1;
                    m_tgt  = Branch_Target_ID;
                    if (!DS) m_drop = 1'b1;
                end
            end
            if (!IF_ID_pipeline_stall) begin
                if (deliver) begin
                    m_instr = imem_rdata; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
                end else begin
                    m_instr = 32'h0; m_valid = 1'b0;
                end
            end
            if (!deliver && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic step(input logic rst, input logic ps, input logic fs, input logic br,
                        input logic [31:0] tgt, input logic vld, input logic [31:0] rd);
        reset = rst; pc_stall = ps; IF_ID_pipeline_stall = fs; PCSrc_ID = br;
        Branch_Target_ID = tgt; imem_valid = vld; imem_rdata = rd;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".Instruction_ID"}, Instruction_ID, m_instr);
        chk({tag, ".Valid_ID"}, {31'h0, Valid_ID}, {31'h0, m_valid});
        chk({tag, ".PC_Plus4_ID"}, PC_Plus4_ID, m_pc4);
        chk({tag, ".Stall_Count"}, {16'h0, Stall_Count}, {16'h0, m_cnt});
    endtask

    initial begin
        int c1, c2, c3;
        c1 = DS ? 3 : 4;
        c2 = DS ? 6 : 8;
        c3 = DS ? 8 : 11;

        //   rst ps fs br  tgt           vld rd             addr          instr                       v    cnt     pc4
        add(1, 0, 0, 0, 32'h0,        1, w(32'h0),    32'h0,        32'h0,                      0,   0,      32'h0);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h0),    32'h4,        w(32'h0),                   1,   0,      32'h4);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h4),    32'h8,        w(32'h4),                   1,   0,      32'h8);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,       32'h8,        32'h0,                      0,   1,      32'h8);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,       32'h8,        32'h0,                      0,   2,      32'h8);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,       32'h8,        32'h0,                      0,   3,      32'h8);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h8),    32'hC,        w(32'h8),                   1,   3,      32'hC);
        add(0, 0, 0, 0, 32'h0,        1, w(32'hC),    32'h10,       w(32'hC),                   1,   3,      32'h10);
        add(0, 0, 0, 1, 32'h40,       1, w(32'h10),   32'h40,       DS ? w(32'h10) : 32'h0,     DS,  c1,     DS ? 32'h14 : 32'h10);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h40),   32'h44,       w(32'h40),                  1,   c1,     32'h44);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,       32'h44,       32'h0,                      0,   c1 + 1, 32'h44);
        add(0, 0, 0, 1, 32'h80,       0, 32'h0,       32'h44,       32'h0,                      0,   c1 + 2, 32'h44);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,       32'h44,       32'h0,                      0,   c1 + 3, 32'h44);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h44),   32'h80,       DS ? w(32'h44) : 32'h0,     DS,  c2,     DS ? 32'h48 : 32'h44);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h80),   32'h84,       w(32'h80),                  1,   c2,     32'h84);
        add(0, 1, 1, 1, 32'h200,      1, w(32'h84),   32'h84,       w(32'h80),                  1,   c2 + 1, 32'h84);
        add(0, 1, 1, 0, 32'h0,        1, w(32'h84),   32'h84,       w(32'h80),                  1,   c2 + 2, 32'h84);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h84),   32'h88,       w(32'h84),                  1,   c2 + 2, 32'h88);
        add(0, 0, 0, 1, 32'hFFFF_FFFC, 1, w(32'h88),  32'hFFFF_FFFC, DS ? w(32'h88) : 32'h0,    DS,  c3,     DS ? 32'h8C : 32'h88);
        add(0, 0, 0, 0, 32'h0,        1, w(32'hFFFC), 32'h0,        w(32'hFFFC),                1,   c3,     32'h0);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h0),    32'h4,        w(32'h0),                   1,   c3,     32'h4);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,       32'h4,        32'h0,                      0,   c3 + 1, 32'h4);
        add(1, 0, 0, 0, 32'h0,        1, w(32'h4),    32'h0,        32'h0,                      0,   0,      32'h0);
        add(0, 0, 0, 0, 32'h0,        1, w(32'h0),    32'h4,        w(32'h0),                   1,   0,      32'h4);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].ps, tbl[i].fs, tbl[i].br, tbl[i].tgt, tbl[i].vld, tbl[i].rd);
            chk($sformatf("vec%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d.Instruction_ID", i), Instruction_ID, tbl[i].e_instr);
            chk($sformatf("vec%0d.Valid_ID", i), {31'h0, Valid_ID}, {31'h0, tbl[i].e_valid});
            chk($sformatf("vec%0d.Stall_Count", i), {16'h0, Stall_Count}, {16'h0, tbl[i].e_cnt});
            chk($sformatf("vec%0d.PC_Plus4_ID", i), PC_Plus4_ID, tbl[i].e_pc4);
        end

        // Randomized traffic starting from a fresh reset.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_model("rand_reset");
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_ps, r_fs, r_br, r_vld;
            logic [31:0] r_tgt, r_rd;
            r_rst = ($urandom_range(0, 99) == 0);
            r_ps  = ($urandom_range(0, 7) == 0);
            r_fs  = ($urandom_range(0, 7) == 0);
            r_br  = ($urandom_range(0, 5) == 0);
            r_vld = ($urandom_range(0, 1) == 1);
            r_tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            r_rd  = $urandom;
            step(r_rst, r_ps, r_fs, r_br, r_tgt, r_vld, r_rd);
            chk_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: IF_Fetch_Stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; reset SHALL be sampled only on the rising edge of clk.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-004 Port reset, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Port pc_stall, input, 1, SHALL hold the PC (from the hazard unit).
REQ-006 Port IF_ID_pipeline_stall, input, 1, SHALL hold the IF/ID register.
REQ-007 Port PCSrc_ID, input, 1, SHALL be a one-cycle pulse marking a taken branch resolved in ID.
REQ-008 Port Branch_Target_ID, input, 32, SHALL be the taken-branch target, valid when PCSrc_ID=1.
REQ-009 Port imem_addr, output, 32, SHALL be the fetch address, driven combinationally from the PC register.
REQ-010 Port imem_rdata, input, 32, SHALL be the instruction word, valid when imem_valid=1.
REQ-011 Port imem_valid, input, 1, SHALL mark imem_rdata valid for imem_addr; memory latency is variable (0..N cycles).
REQ-012 Ports Instruction_ID (32), PC_Plus4_ID (32) and Valid_ID (1), outputs, SHALL form the IF/ID register.
REQ-013 Port Stall_Count, output, 16, SHALL be a saturating count of lost fetch cycles.

Function
REQ-014 States SHALL be FETCH, WAIT and DISCARD; the state register SHALL update only on the clk edge.
REQ-015 Priority SHALL be reset > pc_stall > PCSrc_ID > imem_valid.
REQ-016 In FETCH with imem_valid=1 and no stall or branch, the block SHALL set PC<=PC+4 and load Instruction_ID<=imem_rdata, PC_Plus4_ID<=PC+4 and Valid_ID<=1 (1-cycle latency).
REQ-017 In FETCH with imem_valid=0, the block SHALL hold PC, load a bubble (Instruction_ID=32'h0, Valid_ID=0) and go to WAIT.
REQ-018 In WAIT, PC and imem_addr SHALL stay constant, and the block SHALL insert a bubble each cycle until imem_valid=1; it SHALL then behave as in REQ-016 and return to FETCH.
REQ-019 pc_stall=1 SHALL hold PC and the state; PCSrc_ID in the same cycle SHALL be ignored, because the hazard unit re-asserts the branch after the stall.
REQ-020 IF_ID_pipeline_stall=1 SHALL hold all IF/ID outputs unchanged, overriding any bubble or load.
REQ-021 If PCSrc_ID=1 in FETCH with imem_valid=1, the block SHALL set PC<=Branch_Target_ID; the IF/ID load is defined in REQ-030.
REQ-022 If PCSrc_ID=1 while no word is available (FETCH with imem_valid=0, or WAIT), the block SHALL latch the target into redirect_target and set redirect_pending=1.
REQ-023 When the outstanding word arrives with redirect_pending=1, the block SHALL set PC<=redirect_target and clear redirect_pending.
REQ-024 The block SHALL never change imem_addr while a fetch is outstanding (WAIT or DISCARD).
REQ-025 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0.
REQ-026 Stall_Count SHALL increment each cycle in which pc_stall=1 or a bubble is inserted, saturating at 16'hFFFF.
REQ-027 PCSrc_ID and imem_valid asserted in the same cycle SHALL complete the fetch and apply the redirect in that same cycle.

Reset
REQ-028 reset=1 SHALL set PC=RESET_PC, state=FETCH, Instruction_ID=32'h0, PC_Plus4_ID=32'h0, Valid_ID=0, redirect_pending=0, redirect_target=32'h0 and Stall_Count=0.
REQ-029 Reset during WAIT or DISCARD SHALL abandon the outstanding fetch; an imem_valid in the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro BRANCH_DELAY_SLOT_EN SHALL select taken-branch handling:
- Defined: the word fetched in the branch cycle, or the outstanding word, is the delay slot and SHALL load into IF/ID with Valid_ID=1; WAIT+PCSrc_ID stays in WAIT.
- Undefined: that word SHALL be discarded (bubble into IF/ID); WAIT+PCSrc_ID SHALL go to DISCARD, which drops the arriving word, applies REQ-023 and then returns to FETCH.

Verification
REQ-031 Reset, imem_valid held at 1, words A,B,C -> imem_addr 0,4,8; Instruction_ID A,B,C one cycle later; Valid_ID=1; Stall_Count=0.
REQ-032 imem_valid low for 3 cycles at PC=8 -> imem_addr stays 8, 3 bubbles, Stall_Count=3, then the word at 8 loads.
REQ-033 PCSrc_ID=1 with target 0x40 at PC=0x10 -> next imem_addr=0x40; word at 0x10 loads with the macro defined, bubble without it.
REQ-034 PCSrc_ID during WAIT (target 0x80), word arrives 2 cycles later -> address stays put until arrival, then PC=0x80; word dropped without macro, delivered with it.
REQ-035 pc_stall and PCSrc_ID together, then IF_ID_pipeline_stall for 2 cycles -> PC unchanged, redirect ignored, IF/ID outputs frozen 2 cycles.
REQ-036 PC=0xFFFF_FFFC fetch -> next PC 0x0; reset asserted mid-WAIT -> PC=RESET_PC and all outputs at reset values.
